regfile_hilo: RTL
=================

# regfile_hilo

Architectural register storage at the receiving end of the write-back stage: 31 writable 32-bit GPRs (r0 hard-wired to zero), the HI/LO pair, and a per-register pending-write scoreboard. It absorbs the write-back port (`wa3`/`wd3`/`write_enable`, `hi_write`/`lo_write`/`hi_data`/`lo_data`) and serves two combinational GPR read ports plus HI/LO to decode. Busy flags from the scoreboard drive decode's stall logic.

## Interface
Parameters:
- `SB_W`, default 2: scoreboard counter width per register; maximum in-flight writes per register is 2^SB_W-1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ra1`, `ra2`  in  5 each  read addresses (creg_addr_t).
- `rd1`, `rd2`  out  32 each  read data (word_t).
- `busy1`, `busy2`  out  1 each  a write to `ra1`/`ra2` is still pending.
- `wa3`  in  5  write-back destination.
- `wd3`  in  32  write-back data.
- `write_enable`  in  1  GPR write strobe.
- `hi_write`, `lo_write`  in  1 each  HI/LO write strobes.
- `hi_data`, `lo_data`  in  32 each  HI/LO write data.
- `hi`, `lo`  out  32 each  HI/LO read data.
- `mark_en`  in  1  decode issued an instruction writing `mark_addr`.
- `mark_addr`  in  5  destination being marked.
- `flush`  in  1  clear all scoreboard counters.
- `sb_overflow`  out  1  one-cycle pulse: mark attempted on a saturated counter.

## Operation
- Reset: all GPRs 0, `hi`/`lo` 0, all counters 0, `sb_overflow` 0.
- Reads: combinational. `ra==0` yields 0 and busy 0.
- GPR write: when `write_enable && wa3!=0`, `gpr[wa3] <= wd3` at the edge. Writes to r0 are dropped.
- HI/LO: `hi_write` loads `hi_data`, `lo_write` loads `lo_data`; independent, both may be asserted in the same cycle.
- Scoreboard counter `cnt[r]` (SB_W bits), r=1..31:
  - mark only (`mark_en && mark_addr==r`): +1.
  - write only (`write_enable && wa3==r`): −1; a write with `cnt==0` leaves it at 0.
  - both in the same cycle for the same r: unchanged.
  - mark at the maximum with no simultaneous write: stays at the maximum, `sb_overflow`=1 for the following cycle.
  - marks and writes to r0 are ignored.
  - `flush`: all counters go to 0 next cycle and override marks and writes in that cycle. GPR and HI/LO writes in the same cycle still commit.
- `busyN = (cnt[raN]!=0)`, modified by the bypass rule below.
- `reset` has priority over every other input. A reset asserted mid-stream discards all pending counts and data.

## Timing
- Read latency: 0 cycles (combinational from `ra*` and state).
- Write visibility: without bypass, a value written at edge k appears on `rd*`/`hi`/`lo` from cycle k+1.
- `sb_overflow`: registered, asserted exactly one cycle after the offending mark.
- Counter updates take effect at the edge. Busy for a newly marked register rises in the cycle after `mark_en`.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - When `write_enable && wa3==raN && wa3!=0`, `rdN=wd3` in the same cycle.
  - `busyN` uses `cnt−1` (floored at 0) for that register, so the last pending write clears busy in its own write cycle.
  - `hi`/`lo` bypass `hi_data`/`lo_data` when their strobe is high.
- `REGFILE_BYPASS_EN` not defined:
  - `rd*`, `hi`, `lo` and `busy*` reflect registered state only.

## Test plan
- Reset, then read every `ra1`/`ra2` from 0 to 31 -> `rd*`=0, `busy*`=0, `hi`=`lo`=0.
- Write r5=0xDEADBEEF, then write r0=0x1234 -> `rd1`(r5)=0xDEADBEEF and `rd2`(r0)=0 in the next cycle. With bypass, `rd1` already shows 0xDEADBEEF during the write cycle.
- Mark r7 three times, then a fourth mark -> `busy1`=1 and `sb_overflow` pulses once. Three writes to r7 -> `busy1` falls after the third (in its write cycle with bypass, the cycle after without).
- Same-cycle mark and write to r9 with `cnt`=1 -> `cnt` stays 1 and `busy` stays 1. Then `flush` -> `busy` is 0 next cycle.
- `hi_write` and `lo_write` together with 0x1, 0x2, then `lo_write` alone with 0x3 -> `hi`=0x1, `lo`=0x3.
- Mark r3, assert `reset` mid-stream with a write to r3 in the same cycle -> r3=0, `busy`=0, no overflow pulse.

Source files
------------

// File: rtl/regfile_hilo.sv
// regfile_hilo: 31 GPRs (r0 reads zero), HI/LO pair and a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data and busy clearing to readers.
module regfile_hilo #(
  parameter int unsigned SB_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        busy1,
  output logic        busy2,
  input  logic [4:0]  wa3,
  input  logic [31:0] wd3,
  input  logic        write_enable,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] hi_data,
  input  logic [31:0] lo_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  input  logic        mark_en,
  input  logic [4:0]  mark_addr,
  input  logic        flush,
  output logic        sb_overflow
);

  localparam logic [SB_W-1:0] CntMax = {SB_W{1'b1}};
  localparam logic [SB_W-1:0] CntOne = SB_W'(1);

  // Entry 0 of both arrays is held at zero so r0 reads as zero and never busy.
  logic [31:0]     gpr_q [32];
  logic [SB_W-1:0] cnt_q [32];
  logic [SB_W-1:0] cnt_d [32];
  logic [31:0]     hi_q, lo_q;
  logic            ovf_q, ovf_d;

  always_comb begin
    ovf_d    = 1'b0;
    cnt_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (mark_en && mark_addr == 5'(r) && !(write_enable && wa3 == 5'(r))) begin
        if (cnt_q[r] == CntMax) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CntOne;
        end
      end else if (write_enable && wa3 == 5'(r) && !(mark_en && mark_addr == 5'(r)) &&
                   cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        gpr_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      hi_q  <= '0;
      lo_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (write_enable && wa3 != 5'd0) gpr_q[wa3] <= wd3;
      if (hi_write) hi_q <= hi_data;
      if (lo_write) lo_q <= lo_data;
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    rd1   = (ra1 == 5'd0) ? 32'd0 : gpr_q[ra1];
    rd2   = (ra2 == 5'd0) ? 32'd0 : gpr_q[ra2];
    busy1 = (cnt_q[ra1] != '0);
    busy2 = (cnt_q[ra2] != '0);
    hi    = hi_q;
    lo    = lo_q;
`ifdef REGFILE_BYPASS_EN
    // cnt-1 floored at zero is nonzero exactly when cnt > 1.
    if (write_enable && wa3 == ra1 && wa3 != 5'd0) begin
      rd1   = wd3;
      busy1 = (cnt_q[ra1] > CntOne);
    end
    if (write_enable && wa3 == ra2 && wa3 != 5'd0) begin
      rd2   = wd3;
      busy2 = (cnt_q[ra2] > CntOne);
    end
    if (hi_write) hi = hi_data;
    if (lo_write) lo = lo_data;
`endif
  end

  assign sb_overflow = ovf_q;

endmodule
